// File: rtl/tx_fifo_feeder.sv
// Byte queue in front of a UART transmitter: buffers written bytes and issues
// them one at a time with a start pulse, waiting for the transmitter's done tick.
module tx_fifo_feeder #(
  parameter int ADDR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] w_data,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf_tick,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  state_t            state;
  logic              push;
  logic              pop;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push      = wr && !full;
  assign pop       = (state == IDLE) && !empty;
  assign fsm_state = state;

  // Storage is deliberately left unreset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_tick <= 1'b0;
    end else begin
      ovf_tick <= wr && full;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs are registered so tx_start and busy line up with SEND/WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      din      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SEND;
            din      <= mem[rd_ptr];
            tx_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          state    <= WAIT;
          tx_start <= 1'b0;
        end
        WAIT: begin
          if (tx_done_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Directed and randomized bench for tx_fifo_feeder against a queue-based
// transaction model of the byte feeder.
module tb_tx_fifo_feeder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf_tick;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, transmitter availability, last issued byte.
  logic [7:0] exp_q[$];
  logic       m_free;
  logic       m_start;
  logic [7:0] m_din;
  logic       m_ovf;
  int         since_start;

  tx_fifo_feeder #(.ADDR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .din          (din),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .ovf_tick     (ovf_tick),
    .fsm_state    (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_free      = 1'b1;
    m_start     = 1'b0;
    m_din       = 8'h00;
    m_ovf       = 1'b0;
    since_start = 0;
  endtask

  // One clock edge of the feeder, described in terms of the queue and the link.
  task automatic model_edge(input logic w, input logic [7:0] d, input logic done);
    int  n;
    logic take;
    n     = exp_q.size();
    take  = m_free && (n > 0);
    m_ovf = w && (n == DEPTH);
    if (take) begin
      m_din   = exp_q.pop_front();
      m_free  = 1'b0;
      m_start = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
    end else if (!m_free && done) begin
      m_free = 1'b1;
    end
    if (w && (n < DEPTH)) exp_q.push_back(d);
    since_start = m_start ? 0 : since_start + 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tx_start", {7'd0, tx_start}, {7'd0, m_start});
    chk("din", din, m_din);
    chk("busy", {7'd0, busy}, {7'd0, !m_free});
    chk("full", {7'd0, full}, {7'd0, exp_q.size() == DEPTH});
    chk("empty", {7'd0, empty}, {7'd0, exp_q.size() == 0});
    chk("ovf_tick", {7'd0, ovf_tick}, {7'd0, m_ovf});
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic done);
    wr           = w;
    w_data       = d;
    tx_done_tick = done;
    @(posedge clk);
    model_edge(w, d, done);
    #1;
    check_all();
  endtask

  initial begin
    int starts;
    reset        = 1'b0;
    wr           = 1'b0;
    w_data       = 8'h00;
    tx_done_tick = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // Single byte: latency and busy until done.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat_no_start_yet", {7'd0, tx_start}, 8'd0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lat_start_A5", {tx_start, din[6:0]}, {1'b1, 7'h25});
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("busy_after_done", {7'd0, busy}, 8'd0);
    cycle(1'b0, 8'h00, 1'b0);

    // Three bytes, done tick 20 cycles after each start.
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    starts = 1;
    for (int i = 0; i < 90; i++) begin
      cycle(1'b0, 8'h00, (since_start == 19) && !m_free);
      if (tx_start) starts++;
    end
    chk("three_starts", 8'(starts), 8'd3);
    chk("last_din_03", din, 8'h03);

    // Done tick while idle and empty changes nothing.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Overflow: six writes with the transmitter stalled.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    chk("ovf_on_15", {7'd0, ovf_tick}, 8'd1);
    chk("full_after_14", {7'd0, full}, 8'd1);
    chk("din_10", din, 8'h10);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_single_pulse", {7'd0, ovf_tick}, 8'd0);

    // Write collides with done while full: dropped, then pop proceeds.
    cycle(1'b1, 8'h77, 1'b1);
    chk("ovf_collide", {7'd0, ovf_tick}, 8'd1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("pop_after_collide", {tx_start, full, din[6:0] == 7'h11, 5'd0}, {1'b1, 1'b0, 1'b1, 5'd0});
    cycle(1'b0, 8'h00, 1'b0);

    // Asynchronous reset in WAIT with three queued.
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h5C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("start_after_reset", {tx_start, din[6:0]}, {1'b1, 7'h5C});
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("drained", {7'd0, empty}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
